// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared encodings for the execute stage: ALUOp/funct codes,
//               internal ALU operation and MUL sequencer state types.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] c_ALUOP_ITYPE = 2'b11;

    localparam logic [9:0] c_FUNCT_ADD = 10'b0000000_000;
    localparam logic [9:0] c_FUNCT_SUB = 10'b0100000_000;
    localparam logic [9:0] c_FUNCT_AND = 10'b0000000_111;
    localparam logic [9:0] c_FUNCT_OR  = 10'b0000000_110;
    localparam logic [9:0] c_FUNCT_XOR = 10'b0000000_100;
    localparam logic [9:0] c_FUNCT_SLL = 10'b0000000_001;
    localparam logic [9:0] c_FUNCT_MUL = 10'b0000001_000;

    localparam logic [2:0] c_F3_ADDI = 3'b000;
    localparam logic [2:0] c_F3_SRAI = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRA = 4'd6,
        ALU_MUL = 4'd7,
        ALU_NOP = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Unrecognised codes map to NOP, which produces a zero result.
    function automatic alu_op_e decode_op(input logic [1:0] aluop, input logic [9:0] funct);
        alu_op_e op;
        op = ALU_NOP;
        case (aluop)
            c_ALUOP_ADD: op = ALU_ADD;
            c_ALUOP_SUB: op = ALU_SUB;
            c_ALUOP_RTYPE: begin
                case (funct)
                    c_FUNCT_ADD: op = ALU_ADD;
                    c_FUNCT_SUB: op = ALU_SUB;
                    c_FUNCT_AND: op = ALU_AND;
                    c_FUNCT_OR:  op = ALU_OR;
                    c_FUNCT_XOR: op = ALU_XOR;
                    c_FUNCT_SLL: op = ALU_SLL;
                    c_FUNCT_MUL: op = ALU_MUL;
                    default:     op = ALU_NOP;
                endcase
            end
            default: begin
                case (funct[2:0])
                    c_F3_ADDI: op = ALU_ADD;
                    c_F3_SRAI: op = ALU_SRA;
                    default:   op = ALU_NOP;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier, one partial product per cycle,
//               returning the low DATA_W bits of the product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              idle_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int                 c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    mul_state_e         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [DATA_W-1:0]  r_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start_i) begin
                        r_mcand  <= a_i;
                        r_mplier <= b_i;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    // Multiplicand bits shifted past DATA_W cannot reach the low word.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= MUL_DONE;
                    end
                end
                MUL_DONE: r_state <= MUL_IDLE;
                default:  r_state <= MUL_IDLE;
            endcase
        end
    end

    assign idle_o    = (r_state == MUL_IDLE);
    assign busy_o    = (r_state == MUL_BUSY);
    assign done_o    = (r_state == MUL_DONE);
    assign product_o = r_acc;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Pipeline execute stage: operand forwarding, ALU, iterative
//               MUL with upstream stall, and the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic [9:0]        funct_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] exmem_alu_o,
    output logic [DATA_W-1:0] exmem_wdata_o,
    output logic [REG_AW-1:0] exmem_rd_o,
    output logic              exmem_regwrite_o,
    output logic              exmem_memtoreg_o,
    output logic              exmem_memwrite_o,
    output logic              exmem_memread_o
);

    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_result;
    alu_op_e           w_op;
    logic              w_is_mul;
    logic              w_mul_idle;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_memwrite;
    logic              r_memread;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        w_rs_fwd = RSdata_i;
        if (r_regwrite && (r_rd != '0) && (r_rd == RSaddr_i)) begin
            w_rs_fwd = r_alu;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == RSaddr_i)) begin
            w_rs_fwd = memwb_data_i;
        end
    end

    always_comb begin
        w_rt_fwd = RTdata_i;
        if (r_regwrite && (r_rd != '0) && (r_rd == RTaddr_i)) begin
            w_rt_fwd = r_alu;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == RTaddr_i)) begin
            w_rt_fwd = memwb_data_i;
        end
    end

    assign w_op_b   = ALUSrc_i ? immed_i : w_rt_fwd;
    assign w_op     = decode_op(ALUOp_i, funct_i);
    assign w_is_mul = (w_op == ALU_MUL);

    always_comb begin
        w_result = '0;
        case (w_op)
            ALU_ADD: w_result = w_rs_fwd + w_op_b;
            ALU_SUB: w_result = w_rs_fwd - w_op_b;
            ALU_AND: w_result = w_rs_fwd & w_op_b;
            ALU_OR:  w_result = w_rs_fwd | w_op_b;
            ALU_XOR: w_result = w_rs_fwd ^ w_op_b;
            ALU_SLL: w_result = w_rs_fwd << w_op_b[4:0];
            ALU_SRA: w_result = $unsigned($signed(w_rs_fwd) >>> immed_i[4:0]);
            default: w_result = '0;
        endcase
    end

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_is_mul),
        .a_i       (w_rs_fwd),
        .b_i       (w_op_b),
        .idle_o    (w_mul_idle),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_product)
    );

    // Gated by reset so an aborted MUL releases the pipeline immediately.
    assign stall_o = ~rst_i & ((w_mul_idle & w_is_mul) | w_mul_busy);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alu      <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (stall_o) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else begin
            r_alu      <= w_mul_done ? w_product : w_result;
            r_wdata    <= w_rt_fwd;
            r_rd       <= RDaddr_i;
            r_regwrite <= RegWrite_i;
            r_memtoreg <= MemToReg_i;
            r_memwrite <= MemWrite_i;
            r_memread  <= MemRead_i;
        end
    end

    assign exmem_alu_o      = r_alu;
    assign exmem_wdata_o    = r_wdata;
    assign exmem_rd_o       = r_rd;
    assign exmem_regwrite_o = r_regwrite;
    assign exmem_memtoreg_o = r_memtoreg;
    assign exmem_memwrite_o = r_memwrite;
    assign exmem_memread_o  = r_memread;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct {
        logic [31:0] rs, rt, imm;
        logic [4:0]  ra, rb, rd;
        logic [9:0]  funct;
        logic [1:0]  op;
        logic        src, m2r, rw, mw, mr;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] RSdata_i = '0, RTdata_i = '0, immed_i = '0, memwb_data_i = '0;
    logic [4:0]  RSaddr_i = '0, RTaddr_i = '0, RDaddr_i = '0, memwb_rd_i = '0;
    logic [9:0]  funct_i = '0;
    logic [1:0]  ALUOp_i = '0;
    logic        ALUSrc_i = 1'b0, MemToReg_i = 1'b0, RegWrite_i = 1'b0;
    logic        MemWrite_i = 1'b0, MemRead_i = 1'b0, memwb_regwrite_i = 1'b0;
    logic        stall_o;
    logic [31:0] exmem_alu_o, exmem_wdata_o;
    logic [4:0]  exmem_rd_o;
    logic        exmem_regwrite_o, exmem_memtoreg_o, exmem_memwrite_o, exmem_memread_o;

    ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .immed_i(immed_i), .funct_i(funct_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .MemToReg_i(MemToReg_i), .RegWrite_i(RegWrite_i),
        .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .stall_o(stall_o),
        .exmem_alu_o(exmem_alu_o), .exmem_wdata_o(exmem_wdata_o), .exmem_rd_o(exmem_rd_o),
        .exmem_regwrite_o(exmem_regwrite_o), .exmem_memtoreg_o(exmem_memtoreg_o),
        .exmem_memwrite_o(exmem_memwrite_o), .exmem_memread_o(exmem_memread_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected EX/MEM contents and expected stall for the instruction in EX
    logic [31:0] m_alu = '0, m_wdata = '0, n_alu = '0, n_wdata = '0;
    logic [4:0]  m_rd = '0, n_rd = '0;
    logic        m_rw = 1'b0, m_m2r = 1'b0, m_mw = 1'b0, m_mr = 1'b0;
    logic        n_rw = 1'b0, n_m2r = 1'b0, n_mw = 1'b0, n_mr = 1'b0;
    logic        m_stall = 1'b0;
    int          m_pos = -1;      // cycles the current MUL has spent in EX, -1 when none
    logic [31:0] m_ma = '0, m_mb = '0;
    instr_t      cur;
    logic        rand_mw = 1'b0;

    logic [9:0] ftab [10] = '{10'b0000000000, 10'b0100000000, 10'b0000000111, 10'b0000000110,
                              10'b0000000100, 10'b0000000001, 10'b0000001000, 10'b1111111000,
                              10'b0000000010, 10'b0100000111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_mul(input instr_t x);
        return (x.op == 2'b10) && (x.funct == 10'b0000001000);
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] id_data);
        if (m_rw && m_rd != 0 && m_rd == addr) return m_alu;
        if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == addr) return memwb_data_i;
        return id_data;
    endfunction

    function automatic logic [31:0] alu_ref(input instr_t x, input logic [31:0] a, input logic [31:0] b);
        case (x.op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                case (x.funct)
                    10'b0000000000: return a + b;
                    10'b0100000000: return a - b;
                    10'b0000000111: return a & b;
                    10'b0000000110: return a | b;
                    10'b0000000100: return a ^ b;
                    10'b0000000001: return a << b[4:0];
                    default:        return 32'd0;
                endcase
            end
            default: begin
                case (x.funct[2:0])
                    3'b000:  return a + b;
                    3'b101:  return $unsigned($signed(a) >>> x.imm[4:0]);
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    // One compare process: every cycle, DUT against the model
    always @(negedge clk_i) begin
        chk("alu", exmem_alu_o, m_alu);
        chk("wdata", exmem_wdata_o, m_wdata);
        chk("rd", {27'd0, exmem_rd_o}, {27'd0, m_rd});
        chk("ctrl", {28'd0, exmem_regwrite_o, exmem_memtoreg_o, exmem_memwrite_o, exmem_memread_o},
            {28'd0, m_rw, m_m2r, m_mw, m_mr});
        chk("stall", {31'd0, stall_o}, {31'd0, m_stall});
    end

    task automatic apply(input instr_t x);
        cur = x;
        RSdata_i = x.rs;  RTdata_i = x.rt;  immed_i = x.imm;
        RSaddr_i = x.ra;  RTaddr_i = x.rb;  RDaddr_i = x.rd;
        funct_i = x.funct; ALUOp_i = x.op;  ALUSrc_i = x.src;
        MemToReg_i = x.m2r; RegWrite_i = x.rw; MemWrite_i = x.mw; MemRead_i = x.mr;
    endtask

    task automatic model_reset();
        m_alu = '0; m_wdata = '0; m_rd = '0;
        m_rw = 1'b0; m_m2r = 1'b0; m_mw = 1'b0; m_mr = 1'b0;
        m_stall = 1'b0; m_pos = -1;
    endtask

    // A MUL holds EX for DATA_W+1 stalled cycles, then delivers a*b on the next one.
    task automatic eval();
        logic [31:0] a, b, opb;
        a   = fwd(cur.ra, cur.rs);
        b   = fwd(cur.rb, cur.rt);
        opb = cur.src ? cur.imm : b;
        if (is_mul(cur)) begin
            if (m_pos < 0) begin
                m_pos = 0; m_ma = a; m_mb = opb;
            end
            m_stall = (m_pos <= DATA_W);
        end else begin
            m_stall = 1'b0;
        end
        if (m_stall) begin
            n_alu = m_alu; n_wdata = m_wdata; n_rd = m_rd;
            n_rw = 1'b0; n_m2r = 1'b0; n_mw = 1'b0; n_mr = 1'b0;
        end else begin
            n_alu   = is_mul(cur) ? m_ma * m_mb : alu_ref(cur, a, opb);
            n_wdata = b; n_rd = cur.rd;
            n_rw = cur.rw; n_m2r = cur.m2r; n_mw = cur.mw; n_mr = cur.mr;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        m_alu = n_alu; m_wdata = n_wdata; m_rd = n_rd;
        m_rw = n_rw; m_m2r = n_m2r; m_mw = n_mw; m_mr = n_mr;
        if (is_mul(cur)) m_pos = m_stall ? m_pos + 1 : -1;
    endtask

    // Presents x in EX and holds it until the model says EX accepts it.
    task automatic issue(input instr_t x, output int stalls);
        logic fin;
        stalls = 0;
        fin = 1'b0;
        apply(x);
        for (int k = 0; k < 64 && !fin; k++) begin
            if (rand_mw) begin
                memwb_regwrite_i = 1'($urandom_range(0, 1));
                memwb_rd_i       = 5'($urandom_range(0, 7));
                memwb_data_i     = $urandom;
            end
            #1;
            eval();
            if (stall_o) stalls++;
            tick();
            if (!m_stall) fin = 1'b1;
        end
        if (!fin) chk("issue_timeout", 32'd1, 32'd0);
    endtask

    function automatic instr_t mk(input logic [1:0] op, input logic [9:0] funct,
                                  input logic [4:0] ra, input logic [31:0] rs,
                                  input logic [4:0] rb, input logic [31:0] rt,
                                  input logic [4:0] rd, input logic src, input logic [31:0] imm,
                                  input logic rw, input logic mw);
        instr_t x;
        x.op = op; x.funct = funct; x.ra = ra; x.rs = rs; x.rb = rb; x.rt = rt;
        x.rd = rd; x.src = src; x.imm = imm; x.rw = rw; x.mw = mw;
        x.m2r = 1'b0; x.mr = 1'b0;
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int     k;
        x.rs  = $urandom;  x.rt = $urandom;
        x.imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
        x.ra  = 5'($urandom_range(0, 7));
        x.rb  = 5'($urandom_range(0, 7));
        x.rd  = 5'($urandom_range(0, 7));
        x.src = 1'($urandom_range(0, 1));
        x.m2r = 1'($urandom_range(0, 1));
        x.rw  = 1'($urandom_range(0, 1));
        x.mw  = 1'($urandom_range(0, 1));
        x.mr  = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 19);
        x.funct = 10'($urandom);
        if (k < 2)       x.op = 2'b00;
        else if (k < 4)  x.op = 2'b01;
        else if (k < 14) begin x.op = 2'b10; x.funct = ftab[k-4]; end
        else begin
            x.op = 2'b11;
            if (k < 16)      x.funct[2:0] = 3'b000;
            else if (k < 19) x.funct[2:0] = 3'b101;
        end
        if (is_mul(x)) x.src = 1'b0;
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        instr_t x;
        int     st;
        cur = mk(2'b00, 10'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_alu", exmem_alu_o, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        rst_i = 1'b0;

        // add 5 + 7 -> rd 3
        x = mk(2'b10, 10'b0000000000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b0, 32'd0, 1'b1, 1'b0);
        issue(x, st);
        chk("add_result", exmem_alu_o, 32'd12);
        chk("add_rd", {27'd0, exmem_rd_o}, 32'd3);
        chk("add_regwrite", {31'd0, exmem_regwrite_o}, 32'd1);

        // asynchronous reset mid-cycle
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("async_rst_regwrite", {31'd0, exmem_regwrite_o}, 32'd0);
        chk("async_rst_alu", exmem_alu_o, 32'd0);
        chk("async_rst_rd", {27'd0, exmem_rd_o}, 32'd0);
        chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // forwarding priority: EX/MEM rd4=100 beats MEM/WB rd4=50
        x = mk(2'b00, 10'd0, 5'd1, 32'd100, 5'd2, 32'd0, 5'd4, 1'b0, 32'd0, 1'b1, 1'b0);
        issue(x, st);
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_data_i = 32'd50;
        x = mk(2'b01, 10'd0, 5'd4, 32'd0, 5'd6, 32'd1, 5'd5, 1'b0, 32'd0, 1'b1, 1'b0);
        issue(x, st);
        chk("fwd_priority", exmem_alu_o, 32'd99);
        memwb_regwrite_i = 1'b0;

        // MUL: 33 stalled cycles, then the low product word
        x = mk(2'b10, 10'b0000001000, 5'd1, 32'h0001_0003, 5'd2, 32'd5, 5'd6, 1'b0, 32'd0, 1'b1, 1'b0);
        issue(x, st);
        chk("mul_stall_cycles", st, 32'd33);
        chk("mul_product", exmem_alu_o, 32'h0005_000F);
        chk("mul_regwrite", {31'd0, exmem_regwrite_o}, 32'd1);
        chk("mul_rd", {27'd0, exmem_rd_o}, 32'd6);

        x = mk(2'b10, 10'b0000001000, 5'd1, 32'hFFFF_FFFD, 5'd2, 32'd7, 5'd7, 1'b0, 32'd0, 1'b1, 1'b0);
        issue(x, st);
        chk("mul_neg_stall_cycles", st, 32'd33);
        chk("mul_neg_product", exmem_alu_o, 32'hFFFF_FFEB);

        // abort a MUL with reset during its BUSY phase, then re-issue it
        x = mk(2'b10, 10'b0000001000, 5'd1, 32'h0001_0003, 5'd2, 32'd5, 5'd6, 1'b0, 32'd0, 1'b1, 1'b0);
        apply(x);
        for (int k = 0; k < 10; k++) begin
            #1;
            eval();
            tick();
        end
        chk("abort_stall_before", {31'd0, stall_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        issue(x, st);
        chk("abort_reissue_stalls", st, 32'd33);
        chk("abort_reissue_product", exmem_alu_o, 32'h0005_000F);

        // srai by 4
        x = mk(2'b11, 10'b0100000101, 5'd1, 32'h8000_0000, 5'd2, 32'd0, 5'd9, 1'b1, 32'd4, 1'b1, 1'b0);
        issue(x, st);
        chk("srai", exmem_alu_o, 32'hF800_0000);

        // store: base + 8, store data forwarded from MEM/WB
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd7; memwb_data_i = 32'h0000_00AB;
        x = mk(2'b00, 10'd0, 5'd1, 32'h0000_0100, 5'd7, 32'd0, 5'd0, 1'b1, 32'd8, 1'b0, 1'b1);
        issue(x, st);
        chk("store_addr", exmem_alu_o, 32'h0000_0108);
        chk("store_wdata", exmem_wdata_o, 32'h0000_00AB);
        chk("store_memwrite", {31'd0, exmem_memwrite_o}, 32'd1);
        memwb_regwrite_i = 1'b0;

        // randomized traffic against the model
        rand_mw = 1'b1;
        for (int i = 0; i < 250; i++) begin
            x = rand_instr();
            issue(x, st);
        end

        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
